// File: rtl/trig_pkg.sv
// Shared types and helpers for the N-channel trigger coincidence engine.
package trig_pkg;

  localparam int STAT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_HOLDOFF = 2'd2,
    ST_VETO    = 2'd3
  } trig_state_e;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    logic [STAT_W-1:0] r;
    if (v == {STAT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + STAT_W'(1'b1);
    end
    return r;
  endfunction

endpackage

// File: rtl/trig_ack_sync.sv
// Two-flop synchroniser bank for the asynchronous SCROD ACK lines.
module trig_ack_sync #(
  parameter int N_CH = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] async_in,
  output logic [N_CH-1:0] sync_out
);

  logic [N_CH-1:0] meta_q, meta_d;
  logic [N_CH-1:0] sync_q, sync_d;

  // next-state of both synchroniser stages
  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  // synchroniser registers
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/trig_coinc_n.sv
// N-channel trigger coincidence / fan-out engine with holdoff and veto handshake.
// Optional macro TRG_DROP_COUNTER_EN adds the TRG_DROPPED saturating counter.
module trig_coinc_n import trig_pkg::*; #(
  parameter int N_CH    = 12,
  parameter int CW      = $clog2(N_CH + 1),
  parameter int W_PULSE = 8,
  parameter int HOLDOFF = 16,
  parameter int VETO_TO = 20
) (
  input  logic               CLK_42MHZ,
  input  logic               RESET,
  input  logic [N_CH-1:0]    ACK,
  input  logic [N_CH-1:0]    TRG_MASK,
  input  logic [CW-1:0]      MIN_SCRODS_REQUIRED,
  input  logic [W_PULSE-1:0] TRG_WIDTH,
  input  logic               TRG_SOFT,
  input  logic               TRG_FLOW_CTL_EN,
  input  logic               TRG_VETO_RESET,
  input  logic               STAT_CLEAR,
  output logic [N_CH-1:0]    TRG,
  output logic               TRG_NEEDS_VETO,
  output logic [CW-1:0]      TRG_SCROD_COUNT,
  output logic [STAT_W-1:0]  TRG_STATISTICS,
  output logic               TRG_BUSY
`ifdef TRG_DROP_COUNTER_EN
  , output logic [STAT_W-1:0] TRG_DROPPED
`endif
);

  localparam int HW = $clog2(HOLDOFF + 1);

  logic [N_CH-1:0]    ack_s, ack_m_s;
  logic               coinc_s, fire_s, accept_s;
  logic [W_PULSE-1:0] pulse_load_s;

  trig_state_e        state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic               coinc_prev_q, coinc_prev_d;
  logic [W_PULSE-1:0] pcnt_q, pcnt_d;
  logic [HW-1:0]      hcnt_q, hcnt_d;
  logic [VETO_TO-1:0] vcnt_q, vcnt_d;
  logic [N_CH-1:0]    trg_q, trg_d;
  logic [STAT_W-1:0]  stat_q, stat_d;
  logic               busy_q, busy_d;
  logic               veto_q, veto_d;

  trig_ack_sync #(.N_CH(N_CH)) u_sync (
    .clk      (CLK_42MHZ),
    .rst      (RESET),
    .async_in (ACK),
    .sync_out (ack_s)
  );

  // popcount, coincidence edge detect and fire qualification
  always_comb begin
    ack_m_s = ack_s & TRG_MASK;
    count_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      count_d = count_d + CW'(ack_m_s[i]);
    end
    coinc_s      = (MIN_SCRODS_REQUIRED != '0) && (count_q >= MIN_SCRODS_REQUIRED);
    coinc_prev_d = coinc_s;
    fire_s       = (coinc_s && !coinc_prev_q) || TRG_SOFT;
    pulse_load_s = (TRG_WIDTH == '0) ? '0 : (TRG_WIDTH - W_PULSE'(1'b1));
  end

  // trigger FSM next-state and statistics
  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    trg_d    = trg_q;
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fire_s) begin
          state_d  = ST_PULSE;
          pcnt_d   = pulse_load_s;
          trg_d    = TRG_MASK;
          accept_s = 1'b1;
        end else begin
          trg_d = '0;
        end
      end
      ST_PULSE: begin
        if (pcnt_q == '0) begin
          state_d = ST_HOLDOFF;
          trg_d   = '0;
          hcnt_d  = HW'(HOLDOFF - 1);
        end else begin
          pcnt_d = pcnt_q - W_PULSE'(1'b1);
        end
      end
      ST_HOLDOFF: begin
        if (hcnt_q == '0) begin
          if (TRG_FLOW_CTL_EN) begin
            state_d = ST_VETO;
            vcnt_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hcnt_d = hcnt_q - HW'(1'b1);
        end
      end
      ST_VETO: begin
        vcnt_d = vcnt_q + VETO_TO'(1'b1);
        // leaving as the counter would reach all-ones gives 2^VETO_TO-1 veto cycles
        if (TRG_VETO_RESET || (vcnt_d == {VETO_TO{1'b1}})) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_VETO;
        end
      end
      default: begin
        state_d = ST_IDLE;
        trg_d   = '0;
      end
    endcase

    if (STAT_CLEAR) begin
      stat_d = accept_s ? STAT_W'(1'b1) : '0;
    end else if (accept_s) begin
      stat_d = sat_inc(stat_q);
    end else begin
      stat_d = stat_q;
    end
    busy_d = (state_d != ST_IDLE);
    veto_d = (state_d == ST_VETO);
  end

  // state and output registers
  always_ff @(posedge CLK_42MHZ) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      coinc_prev_q <= 1'b0;
      pcnt_q       <= '0;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      trg_q        <= '0;
      stat_q       <= '0;
      busy_q       <= 1'b0;
      veto_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      coinc_prev_q <= coinc_prev_d;
      pcnt_q       <= pcnt_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      trg_q        <= trg_d;
      stat_q       <= stat_d;
      busy_q       <= busy_d;
      veto_q       <= veto_d;
    end
  end

  assign TRG             = trg_q;
  assign TRG_NEEDS_VETO  = veto_q;
  assign TRG_SCROD_COUNT = count_q;
  assign TRG_STATISTICS  = stat_q;
  assign TRG_BUSY        = busy_q;

`ifdef TRG_DROP_COUNTER_EN
  logic [STAT_W-1:0] drop_q, drop_d;
  logic              dropped_s;

  // fire events lost while the engine is busy
  always_comb begin
    dropped_s = fire_s && (state_q != ST_IDLE);
    if (STAT_CLEAR) begin
      drop_d = dropped_s ? STAT_W'(1'b1) : '0;
    end else if (dropped_s) begin
      drop_d = sat_inc(drop_q);
    end else begin
      drop_d = drop_q;
    end
  end

  // drop counter register
  always_ff @(posedge CLK_42MHZ) begin
    if (RESET) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign TRG_DROPPED = drop_q;
`endif

endmodule

// File: tb/tb_trig_coinc_n.sv
// Scoreboard bench for trig_coinc_n: expected pulses queued by stimulus, checked by a TRG monitor.
module tb_trig_coinc_n;

  localparam int N   = 12;
  localparam int CW  = 4;
  localparam int VTO = 4;

  logic          clk = 1'b0;
  logic          RESET;
  logic [N-1:0]  ACK, TRG_MASK, TRG;
  logic [CW-1:0] MIN_SCRODS_REQUIRED, TRG_SCROD_COUNT;
  logic [7:0]    TRG_WIDTH;
  logic          TRG_SOFT, TRG_FLOW_CTL_EN, TRG_VETO_RESET, STAT_CLEAR;
  logic          TRG_NEEDS_VETO, TRG_BUSY;
  logic [31:0]   TRG_STATISTICS;
`ifdef TRG_DROP_COUNTER_EN
  logic [31:0]   TRG_DROPPED;
`endif

  always #12 clk = ~clk;

  trig_coinc_n #(.N_CH(N), .VETO_TO(VTO)) dut (
    .CLK_42MHZ           (clk),
    .RESET               (RESET),
    .ACK                 (ACK),
    .TRG_MASK            (TRG_MASK),
    .MIN_SCRODS_REQUIRED (MIN_SCRODS_REQUIRED),
    .TRG_WIDTH           (TRG_WIDTH),
    .TRG_SOFT            (TRG_SOFT),
    .TRG_FLOW_CTL_EN     (TRG_FLOW_CTL_EN),
    .TRG_VETO_RESET      (TRG_VETO_RESET),
    .STAT_CLEAR          (STAT_CLEAR),
    .TRG                 (TRG),
    .TRG_NEEDS_VETO      (TRG_NEEDS_VETO),
    .TRG_SCROD_COUNT     (TRG_SCROD_COUNT),
    .TRG_STATISTICS      (TRG_STATISTICS),
    .TRG_BUSY            (TRG_BUSY)
`ifdef TRG_DROP_COUNTER_EN
    , .TRG_DROPPED       (TRG_DROPPED)
`endif
  );

  typedef struct {
    logic [N-1:0] mask;
    int           width;
    int           start;
    logic [31:0]  stat;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] model_stat = 32'd0;
  int          model_drop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int popcnt(input logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += v[i] ? 1 : 0;
    return c;
  endfunction

  task automatic push_exp(input logic [N-1:0] mask, input int wreg, input int start);
    exp_t e;
    if (model_stat != 32'hFFFF_FFFF) model_stat = model_stat + 32'd1;
    e.mask  = mask;
    e.width = (wreg == 0) ? 1 : wreg;
    e.start = start;
    e.stat  = model_stat;
    sbq.push_back(e);
  endtask

  task automatic cfg(input logic [N-1:0] mask, input int w, input int mn, input logic flow);
    TRG_MASK            = mask;
    TRG_WIDTH           = 8'(w);
    MIN_SCRODS_REQUIRED = CW'(mn);
    TRG_FLOW_CTL_EN     = flow;
    repeat (4) tick();
  endtask

  task automatic soft_pulse();
    TRG_SOFT = 1'b1;
    tick();
    TRG_SOFT = 1'b0;
  endtask

  task automatic wait_idle(input bit rand_veto);
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (!TRG_BUSY) begin
        done = 1'b1;
      end else if (rand_veto && TRG_NEEDS_VETO && ($urandom_range(0, 7) == 0)) begin
        TRG_VETO_RESET = 1'b1;
        tick();
        TRG_VETO_RESET = 1'b0;
      end else begin
        tick();
      end
    end
    if (!done) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // monitor: pops an expectation on every TRG rising edge and tracks the pulse
  logic [N-1:0] prev_trg = '0;
  bit           active = 1'b0;
  int           run = 0;
  exp_t         cur;
  always @(negedge clk) begin
    if (TRG != '0 && prev_trg == '0) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", 32'(TRG), 32'd0);
      end else begin
        cur    = sbq.pop_front();
        active = 1'b1;
        run    = 0;
        chk("pulse_start", cyc, cur.start);
        chk("pulse_stat", TRG_STATISTICS, cur.stat);
      end
    end
    if (active) begin
      if (TRG != '0) begin
        chk("pulse_mask", 32'(TRG), 32'(cur.mask));
        run++;
      end else begin
        chk("pulse_width", run, cur.width);
        active = 1'b0;
      end
    end
    prev_trg = TRG;
  end

  initial begin
    #(24 * 60000);
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [N-1:0] a, m;
    int w, mn, ec;
    bit fl, sf, fire;

    RESET = 1'b1; ACK = '0; TRG_MASK = '0; MIN_SCRODS_REQUIRED = '0; TRG_WIDTH = 8'd0;
    TRG_SOFT = 1'b0; TRG_FLOW_CTL_EN = 1'b0; TRG_VETO_RESET = 1'b0; STAT_CLEAR = 1'b0;
    repeat (3) tick();
    chk("rst_trg", 32'(TRG), 32'd0);
    chk("rst_busy", 32'(TRG_BUSY), 32'd0);
    chk("rst_veto", 32'(TRG_NEEDS_VETO), 32'd0);
    chk("rst_count", 32'(TRG_SCROD_COUNT), 32'd0);
    chk("rst_stat", TRG_STATISTICS, 32'd0);
    RESET = 1'b0;

    // three channels in coincidence, full mask
    cfg(12'hFFF, 4, 3, 1'b0);
    ACK = 12'h007; k = cyc;
    push_exp(12'hFFF, 4, k + 4);
    repeat (3) tick();
    chk("count_3", 32'(TRG_SCROD_COUNT), 32'd3);
    wait_idle(1'b0);
    ACK = '0; repeat (4) tick();
    chk("stat_1", TRG_STATISTICS, 32'd1);

    // masked-off channels never count; held coincidence fires once
    cfg(12'h00F, 4, 3, 1'b0);
    ACK = 12'hFF0;
    repeat (3) tick();
    chk("count_masked", 32'(TRG_SCROD_COUNT), 32'd0);
    repeat (10) tick();
    ACK = 12'h007; k = cyc;
    push_exp(12'h00F, 4, k + 4);
    repeat (3) tick();
    chk("count_low3", 32'(TRG_SCROD_COUNT), 32'd3);
    repeat (400) tick();
    ACK = '0; repeat (4) tick();
    chk("stat_held", TRG_STATISTICS, model_stat);

    // soft trigger with flow control, soft trigger in veto, veto release
    cfg(12'hFFF, 1, 0, 1'b1);
    k = cyc;
    push_exp(12'hFFF, 1, k + 1);
    soft_pulse();
    repeat (16) tick();
    chk("veto_before_holdoff_end", 32'(TRG_NEEDS_VETO), 32'd0);
    chk("busy_holdoff", 32'(TRG_BUSY), 32'd1);
    tick();
    chk("veto_on", 32'(TRG_NEEDS_VETO), 32'd1);
    soft_pulse(); model_drop++;
    repeat (3) tick();
    chk("veto_hold", 32'(TRG_NEEDS_VETO), 32'd1);
    TRG_VETO_RESET = 1'b1; tick(); TRG_VETO_RESET = 1'b0;
    chk("veto_released", 32'(TRG_NEEDS_VETO), 32'd0);
    chk("busy_released", 32'(TRG_BUSY), 32'd0);

    // veto timeout: 2^4-1 cycles
    k = cyc;
    push_exp(12'hFFF, 1, k + 1);
    soft_pulse();
    repeat (31) tick();
    chk("veto_last", 32'(TRG_NEEDS_VETO), 32'd1);
    tick();
    chk("veto_timeout", 32'(TRG_NEEDS_VETO), 32'd0);
    chk("busy_timeout", 32'(TRG_BUSY), 32'd0);

    // clear coincident with an accepted fire
    cfg(12'h0F0, 2, 0, 1'b0);
    k = cyc;
    STAT_CLEAR = 1'b1; model_stat = 32'd0; model_drop = 0;
    push_exp(12'h0F0, 2, k + 1);
    soft_pulse();
    STAT_CLEAR = 1'b0;
    wait_idle(1'b0);
    chk("stat_clear_fire", TRG_STATISTICS, 32'd1);

    // two soft triggers dropped during an 8-cycle pulse
    cfg(12'hFFF, 8, 0, 1'b0);
    k = cyc;
    push_exp(12'hFFF, 8, k + 1);
    soft_pulse();
    soft_pulse(); soft_pulse(); model_drop += 2;
    wait_idle(1'b0);
`ifdef TRG_DROP_COUNTER_EN
    chk("dropped", TRG_DROPPED, 32'(model_drop));
`endif

    // reset in the second cycle of an 8-cycle pulse
    cfg(12'hA5A, 8, 0, 1'b0);
    k = cyc;
    push_exp(12'hA5A, 2, k + 1);
    soft_pulse();
    tick();
    RESET = 1'b1; tick();
    chk("rst_mid_trg", 32'(TRG), 32'd0);
    chk("rst_mid_busy", 32'(TRG_BUSY), 32'd0);
    RESET = 1'b0; model_stat = 32'd0; model_drop = 0;
    tick();
    chk("rst_mid_stat", TRG_STATISTICS, 32'd0);

    // randomized transactions
    for (int it = 0; it < 40; it++) begin
      m = 12'($urandom) | (12'd1 << $urandom_range(0, N - 1));
      w = $urandom_range(0, 6);
      mn = $urandom_range(0, 5);
      fl = 1'($urandom_range(0, 1));
      sf = ($urandom_range(0, 3) == 0);
      cfg(m, w, mn, fl);
      if (sf) begin
        k = cyc;
        push_exp(m, w, k + 1);
        soft_pulse();
        fire = 1'b1;
      end else begin
        a = 12'($urandom);
        ec = popcnt(a & m);
        fire = (mn != 0) && (ec >= mn);
        ACK = a; k = cyc;
        if (fire) push_exp(m, w, k + 4);
        repeat (3) tick();
        chk("rand_count", 32'(TRG_SCROD_COUNT), 32'(ec));
        if (fire) repeat (2) tick();
      end
      if (fire) begin
        TRG_MASK = 12'($urandom);
        ACK = '0;
        repeat (2) tick();
        if ($urandom_range(0, 1) == 1) begin
          soft_pulse(); model_drop++;
        end
      end
      ACK = '0;
      wait_idle(1'b1);
      repeat (4) tick();
    end

    repeat (4) tick();
    chk("queue_empty", 32'(sbq.size()), 32'd0);
    chk("final_stat", TRG_STATISTICS, model_stat);
`ifdef TRG_DROP_COUNTER_EN
    chk("final_dropped", TRG_DROPPED, 32'(model_drop));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trig_coinc_n.md
Name: trig_coinc_n

Overview:
- Parametrised N-channel trigger coincidence and fan-out engine; next generation of the 12-SCROD trigger block.
- Sits in the CLK_42MHZ domain between the SCROD ACK inputs / TRG outputs and the Wishbone register slave.
- Counts masked, synchronised ACK lines. Fires a masked, programmable-width TRG pulse on hardware coincidence or soft trigger.
- Enforces holdoff and an optional veto/flow-control handshake. Keeps saturating statistics.

Parameters:
- N_CH, 12, number of SCROD channels (1..32)
- CW, $clog2(N_CH+1), width of coincidence count / threshold
- W_PULSE, 8, width of TRG_WIDTH register
- HOLDOFF, 16, fixed dead-time cycles after pulse end (>=1)
- VETO_TO, 20, width of veto-timeout counter; timeout = 2^VETO_TO-1 cycles

Ports:
- CLK_42MHZ  in  1  trigger clock
- RESET  in  1  synchronous, active-high reset
- ACK  in  N_CH  asynchronous SCROD acknowledge/trigger-request lines
- TRG_MASK  in  N_CH  1 = channel enabled for both coincidence and TRG output
- MIN_SCRODS_REQUIRED  in  CW  coincidence threshold; 0 = hardware trigger disabled
- TRG_WIDTH  in  W_PULSE  TRG pulse length in cycles; 0 treated as 1
- TRG_SOFT  in  1  single-cycle soft-trigger pulse, already in CLK_42MHZ domain
- TRG_FLOW_CTL_EN  in  1  enables veto state after each trigger
- TRG_VETO_RESET  in  1  single-cycle pulse releasing veto
- STAT_CLEAR  in  1  clears statistics counters
- TRG  out  N_CH  trigger outputs
- TRG_NEEDS_VETO  out  1  high while in VETO
- TRG_SCROD_COUNT  out  CW  registered popcount of masked synchronised ACK
- TRG_STATISTICS  out  32  accepted-trigger count, saturating
- TRG_BUSY  out  1  high in any state other than IDLE

Behaviour:
- Reset:
  - All outputs are 0 and the FSM is in IDLE. Synchronisers, counters and the edge register are cleared.
  - RESET mid-pulse drops TRG on the next edge.
- ACK path:
  - 2-FF synchroniser per bit, then ack_m = ack_s & TRG_MASK.
  - TRG_SCROD_COUNT = popcount(ack_m), registered; 3 cycles from ACK to count.
- Coincidence:
  - coinc = (MIN_SCRODS_REQUIRED != 0) && (TRG_SCROD_COUNT >= MIN_SCRODS_REQUIRED).
  - hw_fire = coinc & ~coinc_d, a rising-edge only, so held ACKs do not retrigger.
  - fire = hw_fire | TRG_SOFT.
- FSM states:
  - IDLE: on fire -> PULSE. Load pulse counter with max(TRG_WIDTH,1)-1. TRG <= TRG_MASK on the same edge, so TRG is high 1 cycle after fire. TRG_STATISTICS += 1 unless at 0xFFFFFFFF.
  - PULSE: TRG held at the mask latched at entry; TRG_MASK changes mid-pulse are ignored. Counter decrements; at 0 -> HOLDOFF and TRG <= 0. Pulse lasts exactly max(TRG_WIDTH,1) cycles.
  - HOLDOFF: runs HOLDOFF cycles. Then -> VETO if TRG_FLOW_CTL_EN, else -> IDLE.
  - VETO: TRG_NEEDS_VETO=1. Exit to IDLE on TRG_VETO_RESET, or when the timeout counter reaches all-ones.
- Events outside IDLE:
  - fire is ignored in any state other than IDLE (dropped).
  - coinc_d keeps tracking, so a coincidence held across busy does not fire on return to IDLE.
- Simultaneous events:
  - hw_fire and TRG_SOFT together count as one trigger.
  - STAT_CLEAR together with an accepted fire gives TRG_STATISTICS = 1.
  - TRG_VETO_RESET outside VETO has no effect.
  - TRG_FLOW_CTL_EN is sampled at HOLDOFF exit only.

Optional Feature:
- Macro: TRG_DROP_COUNTER_EN.
- Defined:
  - Adds output TRG_DROPPED [31:0], a saturating count of fire events while TRG_BUSY.
  - Cleared by STAT_CLEAR and RESET.
- Undefined:
  - Port is absent; no counter logic.

Decomposition:
- Package trig_pkg holds:
  - FSM state enum (IDLE, PULSE, HOLDOFF, VETO)
  - STAT_W=32 constant
  - saturating-increment function
- One sub-module, trig_ack_sync: N_CH-wide 2-FF synchroniser with RESET.
- Popcount and FSM stay in the top block.

Test Plan:
- N_CH=12, MASK=0xFFF, MIN=3, TRG_WIDTH=4: raise ACK[2:0] together -> TRG_SCROD_COUNT=3 after 3 cycles. TRG=0xFFF for exactly 4 cycles starting 1 cycle after coinc. TRG_STATISTICS=1.
- MASK=0x00F, MIN=3, ACK=0xFF0 held -> count 0, no TRG. Then ACK=0x007 -> one pulse; TRG=0x00F. ACK held 1000 cycles -> still one pulse.
- MIN=0, TRG_SOFT pulse, TRG_FLOW_CTL_EN=1 -> TRG pulse, then HOLDOFF 16 cycles, then TRG_NEEDS_VETO=1. TRG_SOFT during VETO -> ignored. TRG_VETO_RESET -> NEEDS_VETO=0 next cycle, TRG_BUSY=0.
- Flow control on, no veto reset, VETO_TO=4 override -> NEEDS_VETO drops after 15 cycles.
- Force statistics to 0xFFFFFFFE, fire 3 triggers -> 0xFFFFFFFF. STAT_CLEAR coincident with a fire -> 1.
- RESET asserted in cycle 2 of an 8-cycle pulse -> TRG=0 and TRG_BUSY=0 next edge. With TRG_DROP_COUNTER_EN: 2 soft triggers during PULSE -> TRG_DROPPED=2.
